// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl codes, ALUOp encodings and EX-stage FSM states.
// Imported by ALU control and by the execute unit.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_MUL_RUN,
    EX_MUL_DONE
  } ex_state_e;

  function automatic logic is_mul(input logic [2:0] ctrl);
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: consumes MUL_STEP multiplier bits per step,
// keeps the low XLEN bits of the product. Sequencing is owned by the caller.
module mul_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] product_o,
  output logic            done_o
);

  localparam int N     = XLEN / MUL_STEP;
  localparam int CNT_W = $clog2(N) + 1;

  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  partial;

  // Sum of the MUL_STEP partial products selected by the low multiplier bits.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end else if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      count_d  = '0;
    end else if (step_i) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      count_d  = count_q + CNT_W'(1);
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather
  // than in the sensitivity list; state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  assign product_o = acc_q;
  assign done_o    = step_i && (count_q == CNT_W'(N - 1));

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: combinational single-cycle ops plus an iterative MUL
// that stalls the front of the pipeline until its result is presented.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      ALUCtrl_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            valid_o,
  output logic            stall_o
);

  ex_state_e       state_q, state_d;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mul_product;
  logic            mul_done;
  logic            mul_start, mul_step, mul_clear;
  logic [4:0]      shamt;

  assign shamt = data2_i[4:0];

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_XOR: alu_res = data1_i ^ data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      ALU_SLL: alu_res = data1_i << shamt;
      ALU_SRA: alu_res = XLEN'($signed(data1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  mul_iter #(
    .XLEN    (XLEN),
    .MUL_STEP(MUL_STEP)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (mul_clear),
    .start_i  (mul_start),
    .step_i   (mul_step),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .product_o(mul_product),
    .done_o   (mul_done)
  );

  always_comb begin
    state_d   = state_q;
    result_o  = '0;
    valid_o   = 1'b0;
    stall_o   = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    mul_clear = 1'b0;
    case (state_q)
      EX_IDLE: begin
        if (valid_i) begin
          if (is_mul(ALUCtrl_i)) begin
            stall_o   = 1'b1;
            mul_start = 1'b1;
            state_d   = EX_MUL_RUN;
          end else begin
            result_o = alu_res;
            valid_o  = 1'b1;
          end
        end
      end
      EX_MUL_RUN: begin
        stall_o  = 1'b1;
        mul_step = 1'b1;
        if (mul_done) state_d = EX_MUL_DONE;
      end
      EX_MUL_DONE: begin
        result_o = mul_product;
        valid_o  = 1'b1;
        state_d  = EX_IDLE;
      end
      default: state_d = EX_IDLE;
    endcase
    // Flush overrides everything, including an accept in IDLE.
    if (flush_i) begin
      state_d   = EX_IDLE;
      result_o  = '0;
      valid_o   = 1'b0;
      stall_o   = 1'b0;
      mul_start = 1'b0;
      mul_step  = 1'b0;
      mul_clear = 1'b1;
    end
    if (!rst_i) begin
      result_o = '0;
      valid_o  = 1'b0;
      stall_o  = 1'b0;
    end
  end

  assign zero_o = rst_i && (result_o == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= EX_IDLE;
    else        state_q <= state_d;
  end

endmodule
